// File: rtl/videotex_pkg.sv
// Shared videotex definitions: default colour width, the 8-colour palette and the cell geometry.
// Also holds the pixel-visibility rule shared by the display path.
package videotex_pkg;

  localparam int DEFAULT_COLOR_W = 3;
  localparam int CELL_WIDTH      = 8;

  // Palette ordered {R,G,B}
  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  // A foreground pixel is suppressed while its cell is in the hidden blink phase
  // or concealed without the global reveal override.
  function automatic logic pixel_visible(input logic pixel, input logic blink,
                                         input logic blink_phase, input logic conceal,
                                         input logic reveal);
    return pixel && !(blink && blink_phase) && !(conceal && !reveal);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame-based blink timer: counts frame_start pulses and toggles blink_phase
// every BLINK_FRAMES frames.
module blink_timer #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_count == LAST_FRAME) begin
        frame_count <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// Serialises one 8-pixel character row per cell into a registered one-pixel-per-clock
// RGB stream, applying per-cell colours, blink and conceal attributes.
module pixel_serializer
  import videotex_pkg::*;
#(
  parameter int BLINK_FRAMES = 32,
  parameter int COLOR_W      = DEFAULT_COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [7:0]         row_pixels,
  input  logic [COLOR_W-1:0] fg,
  input  logic [COLOR_W-1:0] bg,
  input  logic               blink,
  input  logic               conceal,
  input  logic               reveal,
  input  logic               display_enable,
  input  logic               frame_start,
  output logic [COLOR_W-1:0] rgb,
  output logic               de_out,
  output logic               blink_phase
);

  localparam int REM_W = $clog2(CELL_WIDTH + 1);
  localparam logic [REM_W-1:0] FULL_CELL = REM_W'(CELL_WIDTH);

  logic [7:0]         shift_q, shift_d;
  logic [REM_W-1:0]   remaining;
  logic [COLOR_W-1:0] fg_q, bg_q, fg_d, bg_d;
  logic               blink_q, conceal_q, blink_d, conceal_d;
  logic               pixel_on;

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // The output register samples the next-state cell so that a load shows its
  // leftmost pixel on the very next clock.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_d   = shift_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    blink_d   = blink_q;
    conceal_d = conceal_q;
    if (load) begin
      shift_d   = row_pixels;
      fg_d      = fg;
      bg_d      = bg;
      blink_d   = blink;
      conceal_d = conceal;
    end else if (remaining != '0) begin
      shift_d = {shift_q[6:0], 1'b0};
    end
    pixel_on = pixel_visible(shift_d[7], blink_d, blink_phase, conceal_d, reveal);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      remaining <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      blink_q   <= 1'b0;
      conceal_q <= 1'b0;
      rgb       <= '0;
      de_out    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      blink_q   <= blink_d;
      conceal_q <= conceal_d;
      if (load) begin
        remaining <= FULL_CELL;
      end else if (remaining != '0) begin
        remaining <= remaining - 1'b1;
      end
      de_out <= display_enable;
      if (!display_enable) begin
        rgb <= '0;
      end else begin
        rgb <= pixel_on ? fg_d : bg_d;
      end
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench for pixel_serializer: a cell-level reference model predicts each
// registered output; a monitor compares every cycle on the falling edge.
module tb_pixel_serializer;

  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] row_pixels = '0;
  logic [2:0] fg = '0, bg = '0;
  logic       blink = 1'b0, conceal = 1'b0, reveal = 1'b0;
  logic       display_enable = 1'b0, frame_start = 1'b0;
  logic [2:0] rgb;
  logic       de_out, blink_phase;

  pixel_serializer #(.BLINK_FRAMES(BF), .COLOR_W(3)) dut (
    .clk(clk), .reset(reset), .load(load), .row_pixels(row_pixels), .fg(fg), .bg(bg),
    .blink(blink), .conceal(conceal), .reveal(reveal), .display_enable(display_enable),
    .frame_start(frame_start), .rgb(rgb), .de_out(de_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rgb;
    logic       de;
    logic       phase;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the cell being shown and how many pixel times since its load.
  logic [7:0] m_word = '0;
  int         m_age = 8;
  logic [2:0] m_fg = '0, m_bg = '0;
  logic       m_blink = 1'b0, m_conceal = 1'b0;
  int         m_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Predict the output for the current inputs, clock them in, then queue the prediction.
  task automatic tick();
    exp_t e;
    logic pix, on, hidden;
    if (reset) begin
      m_word = '0; m_age = 8; m_fg = '0; m_bg = '0;
      m_blink = 1'b0; m_conceal = 1'b0; m_frames = 0;
      e.rgb = '0; e.de = 1'b0; e.phase = 1'b0;
    end else begin
      hidden = ((m_frames / BF) % 2) == 1;
      if (load) begin
        m_word = row_pixels; m_age = 0; m_fg = fg; m_bg = bg;
        m_blink = blink; m_conceal = conceal;
      end else if (m_age < 8) begin
        m_age++;
      end
      pix = (m_age < 8) ? m_word[7 - m_age] : 1'b0;
      on  = pix && !(m_blink && hidden) && !(m_conceal && !reveal);
      e.rgb = !display_enable ? 3'b000 : (on ? m_fg : m_bg);
      e.de  = display_enable;
      if (frame_start) m_frames++;
      e.phase = ((m_frames / BF) % 2) == 1;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    load = 1'b0;
    frame_start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic load_cell(input logic [7:0] row, input logic [2:0] f, input logic [2:0] b);
    row_pixels = row; fg = f; bg = b; load = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rgb", rgb, e.rgb);
      check("de_out", de_out, e.de);
      check("blink_phase", blink_phase, e.phase);
    end
  end

  initial begin
    int guard;
    reset = 1'b1; tick();
    reset = 1'b1; tick();

    // Basic cell followed by an exhausted stretch
    display_enable = 1'b1;
    load_cell(8'b1011_0001, 3'b100, 3'b001);
    repeat (12) tick();

    // Blink: gapless cells, one frame_start per cell
    blink = 1'b1;
    for (int c = 0; c < 6; c++) begin
      load_cell(8'hFF, 3'b010, 3'b101);
      for (int p = 1; p < 8; p++) begin
        frame_start = (p == 3);
        tick();
      end
    end
    blink = 1'b0;

    // Conceal without and with reveal
    conceal = 1'b1; reveal = 1'b0;
    load_cell(8'hA5, 3'b111, 3'b011);
    repeat (7) tick();
    reveal = 1'b1;
    load_cell(8'hA5, 3'b111, 3'b011);
    repeat (7) tick();
    conceal = 1'b0; reveal = 1'b0;

    // Early reload discards the old bits
    load_cell(8'h7F, 3'b110, 3'b010);
    repeat (2) tick();
    load_cell(8'h80, 3'b110, 3'b010);
    repeat (10) tick();

    // Load every cycle shows each word's bit 7
    for (int i = 0; i < 6; i++) load_cell((i % 2) ? 8'h80 : 8'h7F, 3'b101, 3'b000);

    // Reach the hidden blink phase, then reset mid-cell and blank
    guard = 0;
    while (((m_frames / BF) % 2) == 0 && guard < 8) begin
      frame_start = 1'b1; tick(); guard++;
    end
    check("blink_phase_setup", ((m_frames / BF) % 2), 1);
    blink = 1'b1;
    load_cell(8'hFF, 3'b100, 3'b001);
    repeat (3) tick();
    reset = 1'b1; tick();
    blink = 1'b0;
    display_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_cell(8'hC3, 3'b111, 3'b110);
      repeat (3) tick();
    end
    display_enable = 1'b1;
    load_cell(8'hC3, 3'b111, 3'b110);
    repeat (8) tick();

    // Randomised traffic; attributes change freely between loads
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 599) == 0);
      load           = ($urandom_range(0, 5) == 0) || (i % 8 == 0 && i % 64 < 32);
      row_pixels     = 8'($urandom);
      fg             = 3'($urandom);
      bg             = 3'($urandom);
      blink          = ($urandom_range(0, 3) == 0);
      conceal        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) reveal = ~reveal;
      display_enable = ($urandom_range(0, 9) != 0);
      frame_start    = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
